elink_clk_seq: RTL and testbench
================================

Name: elink_clk_seq

Overview:
Parametrised clock/reset sequencer for the elink TX side, replacing the fixed single-channel sequencer. It drives an external PLL/MMCM reset and the Epiphany chip reset, and releases NCH TX channels one at a time. It adds three behaviours the previous sequencer lacked: lock-wait timeout with bounded retries, automatic recovery on lock loss, and sticky status flags. It is pure control logic in the sys_clk domain; clock primitives and per-clock reset synchronisers sit outside it.

Parameters:
RCW, 8, heartbeat counter width; heartbeat period is 2^RCW sys_clk cycles
NCH, 2, number of TX channels
LOCK_TIMEOUT, 16, number of heartbeats to wait for lock in START_CLK/HOLD (must be ≥1)
MAX_RETRY, 3, PLL reset retries allowed before ERROR (must be ≥1)

Ports:
sys_clk  in  1  system clock; all logic on posedge
sys_nreset  in  1  reset, asynchronous, active-low
soft_reset  in  1  software reset/disable, level, sys_clk domain
pll_locked  in  1  PLL lock, asynchronous; synchronised internally
ch_enable  in  NCH  per-channel enable, sys_clk domain
clear_status  in  1  single-cycle pulse; clears sticky flags
pll_reset  out  1  PLL reset, active-high
chip_nreset  out  1  Epiphany chip reset, active-low
tx_active  out  NCH  per-channel active; also serves as the per-channel tx_nreset source
state  out  3  current sequencer state
retry_count  out  RTW=max(1,$clog2(MAX_RETRY+1))  retries used in the current bring-up
lock_err  out  1  sticky: retries exhausted
lock_lost  out  1  sticky: lock dropped while ACTIVE

Behaviour:
- Reset (async): state=RESET_ALL, hb_cnt=0, sync flops=0, wait_cnt=0, rel_cnt=0, retry_count=0.
- Output reset values: pll_reset=1, chip_nreset=0, tx_active=0, lock_err=0, lock_lost=0.
- Heartbeat: hb_cnt increments every cycle and wraps. heartbeat = (hb_cnt == 2^RCW-1), combinational. State transitions, wait_cnt and rel_cnt advance only on heartbeat.
- pll_locked passes through a 2-flop synchroniser to give locked_s. Lock is judged only on locked_s.
- State encoding:
  - RESET_ALL=0, START_CLK=1, STOP_CLK=2, DEASSERT_RESET=3, HOLD=4, ACTIVE=5, ERROR=6, RETRY=7.
- Transitions (evaluated at a heartbeat, listed in priority order):
  - Any state except RESET_ALL: if soft_reset=1, go to RESET_ALL.
  - RESET_ALL: if soft_reset=0, go to START_CLK and clear retry_count.
  - START_CLK and HOLD:
    - if locked_s=1, go to STOP_CLK (from START_CLK) or ACTIVE (from HOLD);
    - else if wait_cnt==LOCK_TIMEOUT-1, then: if retry_count==MAX_RETRY, go to ERROR and set lock_err; otherwise increment retry_count and go to RETRY;
    - else increment wait_cnt.
  - wait_cnt clears on every state change, so a state times out after exactly LOCK_TIMEOUT heartbeats.
  - RETRY: go to START_CLK.
  - STOP_CLK: go to DEASSERT_RESET. DEASSERT_RESET: go to HOLD.
  - ACTIVE: if locked_s=0, go to RESET_ALL and set lock_lost. Re-bring-up follows automatically while soft_reset=0.
  - ERROR: stays until soft_reset=1.
- Decode (combinational from state):
  - pll_reset = state in {RESET_ALL, STOP_CLK, DEASSERT_RESET, RETRY, ERROR}.
  - chip_nreset = state in {DEASSERT_RESET, HOLD, ACTIVE}.
- Channel stagger:
  - rel_cnt clears whenever state≠ACTIVE.
  - In ACTIVE, rel_cnt increments on each heartbeat and saturates at NCH.
  - ch_act[i] = (state==ACTIVE) & ch_enable[i] & (rel_cnt > i).
- Output timing: pll_reset, chip_nreset and tx_active are registered from the decode, so they follow the state register by exactly 1 cycle.
- ch_enable changes:
  - deassertion drops tx_active[i] 2 cycles later (enable sampled by decode, then output register);
  - re-enable after rel_cnt has saturated restores tx_active[i] without further stagger.
- Sticky flags:
  - cleared by clear_status; a set event in the same cycle as clear_status wins.
  - lock_err and lock_lost are not cleared by soft_reset.
- state and retry_count are direct register outputs with no extra stage.
- Reset mid-operation: asynchronous return to all reset values, with no dependence on the heartbeat phase.

Test Plan:
Bench parameters for all scenarios: RCW=2 (heartbeat every 4 cycles), NCH=2, LOCK_TIMEOUT=3, MAX_RETRY=1.
1. Normal bring-up: soft_reset=0, ch_enable=2'b11, pll_locked=1 from 10 cycles after reset release -> state steps 0→1→2→3→4→5 on successive heartbeats; chip_nreset rises 1 cycle after state=3; tx_active[0] rises 1 heartbeat after ACTIVE entry, tx_active[1] 2 heartbeats after ACTIVE entry; pll_reset=0 in ACTIVE.
2. Lock never arrives: pll_locked=0 -> 3 heartbeats in START_CLK, then RETRY (retry_count=1, pll_reset=1), then 3 heartbeats in START_CLK, then ERROR with lock_err=1; state holds at 6 until soft_reset=1 at a heartbeat, then returns to 0.
3. Lock loss: in ACTIVE, drop pll_locked -> state=RESET_ALL within 1 heartbeat plus 2 sync cycles; lock_lost=1; tx_active=0 and chip_nreset=0 one cycle after the state change; with pll_locked restored, re-bring-up completes to ACTIVE.
4. soft_reset during HOLD -> state=0 at the next heartbeat; stays at 0 while soft_reset=1; retry_count clears on leaving RESET_ALL.
5. Channel masking: ch_enable=2'b10 in ACTIVE -> only tx_active[1] rises; deassert ch_enable[1] -> tx_active[1]=0 exactly 2 cycles later; re-enable -> tx_active[1]=1 exactly 2 cycles later.
6. Status and async reset: clear_status in the same cycle as a lock-loss set -> lock_lost=1; a lone clear_status -> lock_lost=0. sys_nreset low mid-ACTIVE -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/elink_clk_seq.sv
// Clock/reset sequencer for the elink TX side: PLL reset, chip reset and
// staggered per-channel release, with lock timeout/retry and lock-loss recovery.
`timescale 1ns/1ps
module elink_clk_seq #(
  parameter int RCW          = 8,
  parameter int NCH          = 2,
  parameter int LOCK_TIMEOUT = 16,
  parameter int MAX_RETRY    = 3,
  localparam int RTW = (MAX_RETRY + 1 > 2) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic           sys_clk,
  input  logic           sys_nreset,
  input  logic           soft_reset,
  input  logic           pll_locked,
  input  logic [NCH-1:0] ch_enable,
  input  logic           clear_status,
  output logic           pll_reset,
  output logic           chip_nreset,
  output logic [NCH-1:0] tx_active,
  output logic [2:0]     state,
  output logic [RTW-1:0] retry_count,
  output logic           lock_err,
  output logic           lock_lost
);

  localparam int WCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RLW = $clog2(NCH + 1);

  localparam logic [2:0] ST_RESET_ALL      = 3'd0;
  localparam logic [2:0] ST_START_CLK      = 3'd1;
  localparam logic [2:0] ST_STOP_CLK       = 3'd2;
  localparam logic [2:0] ST_DEASSERT_RESET = 3'd3;
  localparam logic [2:0] ST_HOLD           = 3'd4;
  localparam logic [2:0] ST_ACTIVE         = 3'd5;
  localparam logic [2:0] ST_ERROR          = 3'd6;
  localparam logic [2:0] ST_RETRY          = 3'd7;

  logic [RCW-1:0] hb_cnt_q;
  logic [1:0]     sync_q;
  logic [2:0]     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RLW-1:0] rel_cnt_q, rel_cnt_d;
  logic [RTW-1:0] retry_q, retry_d;
  logic [NCH-1:0] ch_en_q;
  logic           lock_err_q, lock_err_d;
  logic           lock_lost_q, lock_lost_d;
  logic           pll_reset_q, chip_nreset_q;
  logic [NCH-1:0] tx_active_q;

  logic           heartbeat_s;
  logic           locked_s;
  logic           err_set_s;
  logic           lost_set_s;
  logic           pll_rst_s;
  logic           chip_nrst_s;
  logic [NCH-1:0] ch_act_s;

  assign heartbeat_s = &hb_cnt_q;
  assign locked_s    = sync_q[1];

  // Sequencer next-state, lock-wait counter and retry bookkeeping
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    retry_d    = retry_q;
    err_set_s  = 1'b0;
    lost_set_s = 1'b0;
    if (heartbeat_s) begin
      if (soft_reset && (state_q != ST_RESET_ALL)) begin
        state_d = ST_RESET_ALL;
      end else begin
        case (state_q)
          ST_RESET_ALL: begin
            if (!soft_reset) begin
              state_d = ST_START_CLK;
              retry_d = '0;
            end else begin
              state_d = ST_RESET_ALL;
            end
          end
          ST_START_CLK, ST_HOLD: begin
            if (locked_s) begin
              state_d = (state_q == ST_START_CLK) ? ST_STOP_CLK : ST_ACTIVE;
            end else if (wait_cnt_q == WCW'(LOCK_TIMEOUT - 1)) begin
              if (retry_q == RTW'(MAX_RETRY)) begin
                state_d   = ST_ERROR;
                err_set_s = 1'b1;
              end else begin
                state_d = ST_RETRY;
                retry_d = retry_q + RTW'(1);
              end
            end else begin
              wait_cnt_d = wait_cnt_q + WCW'(1);
            end
          end
          ST_RETRY:          state_d = ST_START_CLK;
          ST_STOP_CLK:       state_d = ST_DEASSERT_RESET;
          ST_DEASSERT_RESET: state_d = ST_HOLD;
          ST_ACTIVE: begin
            if (!locked_s) begin
              state_d    = ST_RESET_ALL;
              lost_set_s = 1'b1;
            end else begin
              state_d = ST_ACTIVE;
            end
          end
          ST_ERROR:          state_d = ST_ERROR;
          default:           state_d = ST_RESET_ALL;
        endcase
      end
      // Every state gets a fresh timeout window
      if (state_d != state_q) begin
        wait_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Channel release counter, sticky status and output decode
  always_comb begin
    rel_cnt_d = rel_cnt_q;
    if (state_q != ST_ACTIVE) begin
      rel_cnt_d = '0;
    end else if (heartbeat_s && (rel_cnt_q != RLW'(NCH))) begin
      rel_cnt_d = rel_cnt_q + RLW'(1);
    end else begin
      rel_cnt_d = rel_cnt_q;
    end

    if (err_set_s) begin
      lock_err_d = 1'b1;
    end else if (clear_status) begin
      lock_err_d = 1'b0;
    end else begin
      lock_err_d = lock_err_q;
    end

    if (lost_set_s) begin
      lock_lost_d = 1'b1;
    end else if (clear_status) begin
      lock_lost_d = 1'b0;
    end else begin
      lock_lost_d = lock_lost_q;
    end

    case (state_q)
      ST_RESET_ALL, ST_STOP_CLK, ST_DEASSERT_RESET, ST_RETRY, ST_ERROR: pll_rst_s = 1'b1;
      default:                                                          pll_rst_s = 1'b0;
    endcase

    case (state_q)
      ST_DEASSERT_RESET, ST_HOLD, ST_ACTIVE: chip_nrst_s = 1'b1;
      default:                               chip_nrst_s = 1'b0;
    endcase

    for (int i = 0; i < NCH; i++) begin
      ch_act_s[i] = (state_q == ST_ACTIVE) && ch_en_q[i] && (rel_cnt_q > RLW'(i));
    end
  end

  // All sequential state; every output is taken from a flop
  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      hb_cnt_q      <= '0;
      sync_q        <= 2'b00;
      state_q       <= ST_RESET_ALL;
      wait_cnt_q    <= '0;
      rel_cnt_q     <= '0;
      retry_q       <= '0;
      ch_en_q       <= '0;
      lock_err_q    <= 1'b0;
      lock_lost_q   <= 1'b0;
      pll_reset_q   <= 1'b1;
      chip_nreset_q <= 1'b0;
      tx_active_q   <= '0;
    end else begin
      hb_cnt_q      <= hb_cnt_q + RCW'(1);
      sync_q        <= {sync_q[0], pll_locked};
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      retry_q       <= retry_d;
      ch_en_q       <= ch_enable;
      lock_err_q    <= lock_err_d;
      lock_lost_q   <= lock_lost_d;
      pll_reset_q   <= pll_rst_s;
      chip_nreset_q <= chip_nrst_s;
      tx_active_q   <= ch_act_s;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign chip_nreset = chip_nreset_q;
  assign tx_active   = tx_active_q;
  assign state       = state_q;
  assign retry_count = retry_q;
  assign lock_err    = lock_err_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_elink_clk_seq.sv
// Directed bench for elink_clk_seq with RCW=2, NCH=2, LOCK_TIMEOUT=3, MAX_RETRY=1.
`timescale 1ns/1ps
module tb_elink_clk_seq;

  logic       sys_clk;
  logic       sys_nreset;
  logic       soft_reset;
  logic       pll_locked;
  logic [1:0] ch_enable;
  logic       clear_status;
  logic       pll_reset;
  logic       chip_nreset;
  logic [1:0] tx_active;
  logic [2:0] state;
  logic [0:0] retry_count;
  logic       lock_err;
  logic       lock_lost;

  int n_checks = 0;
  int n_errors = 0;

  elink_clk_seq #(.RCW(2), .NCH(2), .LOCK_TIMEOUT(3), .MAX_RETRY(1)) dut (
    .sys_clk      (sys_clk),
    .sys_nreset   (sys_nreset),
    .soft_reset   (soft_reset),
    .pll_locked   (pll_locked),
    .ch_enable    (ch_enable),
    .clear_status (clear_status),
    .pll_reset    (pll_reset),
    .chip_nreset  (chip_nreset),
    .tx_active    (tx_active),
    .state        (state),
    .retry_count  (retry_count),
    .lock_err     (lock_err),
    .lock_lost    (lock_lost)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle: just past the next rising edge
  task automatic run(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int k;
    k = 0;
    while ((state !== s) && (k < budget)) begin
      run(1);
      k++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic release_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_nreset = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_pll"}, 32'(pll_reset), 32'd1);
    chk({tag, "_chip"}, 32'(chip_nreset), 32'd0);
    chk({tag, "_tx"}, 32'(tx_active), 32'd0);
    chk({tag, "_retry"}, 32'(retry_count), 32'd0);
    chk({tag, "_err"}, 32'(lock_err), 32'd0);
    chk({tag, "_lost"}, 32'(lock_lost), 32'd0);
  endtask

  initial begin
    sys_nreset   = 1'b1;
    soft_reset   = 1'b0;
    pll_locked   = 1'b0;
    ch_enable    = 2'b11;
    clear_status = 1'b0;
    #2 sys_nreset = 1'b0;
    #1;
    chk_reset_vals("rst");

    // Normal bring-up, lock arrives 10 cycles after release
    release_reset();
    run(3);  chk("s1_c3_state", 32'(state), 32'd0);
    run(1);  chk("s1_c4_state", 32'(state), 32'd1);
    run(6);  pll_locked = 1'b1;
    run(5);  chk("s1_c15_state", 32'(state), 32'd1);
    run(1);  chk("s1_c16_state", 32'(state), 32'd2);
    run(4);  chk("s1_c20_state", 32'(state), 32'd3);
             chk("s1_c20_chip", 32'(chip_nreset), 32'd0);
    run(1);  chk("s1_c21_chip", 32'(chip_nreset), 32'd1);
    run(3);  chk("s1_c24_state", 32'(state), 32'd4);
    run(1);  chk("s1_c25_pll", 32'(pll_reset), 32'd0);
    run(3);  chk("s1_c28_state", 32'(state), 32'd5);
    run(1);  chk("s1_c29_tx", 32'(tx_active), 32'd0);
             chk("s1_c29_pll", 32'(pll_reset), 32'd0);
    run(4);  chk("s1_c33_tx", 32'(tx_active), 32'd1);
    run(4);  chk("s1_c37_tx", 32'(tx_active), 32'd3);

    // Lock loss in ACTIVE
    pll_locked = 1'b0;
    wait_state("s3_lost_state", 3'd0, 6);
    chk("s3_lost_flag", 32'(lock_lost), 32'd1);
    chk("s3_chip_same_cyc", 32'(chip_nreset), 32'd1);
    run(1);
    chk("s3_chip_next", 32'(chip_nreset), 32'd0);
    chk("s3_tx_next", 32'(tx_active), 32'd0);
    chk("s3_pll_next", 32'(pll_reset), 32'd1);
    pll_locked = 1'b1;
    ch_enable  = 2'b10;
    wait_state("s3_rebringup", 3'd5, 40);

    // Channel masking relative to ACTIVE entry
    run(5);  chk("s5_a5_tx", 32'(tx_active), 32'd0);
    run(4);  chk("s5_a9_tx", 32'(tx_active), 32'd2);
    ch_enable = 2'b00;
    run(1);  chk("s5_dis_1cyc", 32'(tx_active), 32'd2);
    run(1);  chk("s5_dis_2cyc", 32'(tx_active), 32'd0);
    ch_enable = 2'b10;
    run(1);  chk("s5_en_1cyc", 32'(tx_active), 32'd0);
    run(1);  chk("s5_en_2cyc", 32'(tx_active), 32'd2);

    // Sticky status: lone clear, then clear colliding with a set
    clear_status = 1'b1;
    run(1);
    clear_status = 1'b0;
    chk("s6_lone_clear", 32'(lock_lost), 32'd0);
    pll_locked = 1'b0;
    run(5);  chk("s6_pre_loss", 32'(state), 32'd5);
    clear_status = 1'b1;
    run(1);
    clear_status = 1'b0;
    chk("s6_loss_state", 32'(state), 32'd0);
    chk("s6_set_wins", 32'(lock_lost), 32'd1);
    pll_locked = 1'b1;
    wait_state("s6_rebringup", 3'd5, 60);
    run(9);
    chk("s6_pre_rst_tx", 32'(tx_active), 32'd2);

    // Async reset between clock edges
    #2 sys_nreset = 1'b0;
    #1;
    chk_reset_vals("s6_async");
    pll_locked = 1'b0;
    soft_reset = 1'b0;

    // Lock never arrives: one retry then ERROR
    release_reset();
    run(4);  chk("s2_c4_state", 32'(state), 32'd1);
    run(12); chk("s2_c16_state", 32'(state), 32'd7);
             chk("s2_c16_retry", 32'(retry_count), 32'd1);
             chk("s2_c16_pll", 32'(pll_reset), 32'd0);
    run(1);  chk("s2_c17_pll", 32'(pll_reset), 32'd1);
    run(3);  chk("s2_c20_state", 32'(state), 32'd1);
    run(11); chk("s2_c31_state", 32'(state), 32'd1);
    run(1);  chk("s2_c32_state", 32'(state), 32'd6);
             chk("s2_c32_err", 32'(lock_err), 32'd1);
    run(8);  chk("s2_c40_state", 32'(state), 32'd6);
    run(1);  soft_reset = 1'b1;
    run(2);  chk("s2_c43_state", 32'(state), 32'd6);
    run(1);  chk("s2_c44_state", 32'(state), 32'd0);
             chk("s2_c44_retry", 32'(retry_count), 32'd1);
             chk("s2_c44_err", 32'(lock_err), 32'd1);

    // soft_reset held, then released; soft_reset again during HOLD
    run(8);  chk("s4_c52_state", 32'(state), 32'd0);
    soft_reset = 1'b0;
    pll_locked = 1'b1;
    run(4);  chk("s4_c56_state", 32'(state), 32'd1);
             chk("s4_c56_retry", 32'(retry_count), 32'd0);
    run(12); chk("s4_c68_state", 32'(state), 32'd4);
    run(1);  soft_reset = 1'b1;
    run(2);  chk("s4_c71_state", 32'(state), 32'd4);
    run(1);  chk("s4_c72_state", 32'(state), 32'd0);
    run(8);  chk("s4_c80_state", 32'(state), 32'd0);
             chk("s4_c80_pll", 32'(pll_reset), 32'd1);
    clear_status = 1'b1;
    run(1);
    clear_status = 1'b0;
    chk("s4_err_cleared", 32'(lock_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
